// File: rtl/usb_crc_engine_if.sv
// Handshake bundle for usb_crc_engine.
// The master side is the packet engine or bench. The slave side is the CRC engine.
//   start       : reinitialise the CRC register; aborts any append
//   din_valid   : din carries DW data bits this cycle, din[0] first on the wire
//   in_ready    : engine accepts data (ACC state)
//   append      : request serialisation of the inverted CRC
//   dout_valid  : dout carries an append beat, dout[0] first on the wire
//   dout_ready  : consumer accepts the append beat
//   crc_out     : live CRC register
//   crc_ok      : crc_out equals the good-packet residue
interface usb_crc_engine_if #(
  parameter int WIDTH = 16,
  parameter int DW    = 1
);
  logic             start;
  logic             din_valid;
  logic [DW-1:0]    din;
  logic             in_ready;
  logic             append;
  logic             dout_valid;
  logic [DW-1:0]    dout;
  logic             dout_ready;
  logic [WIDTH-1:0] crc_out;
  logic             crc_ok;

  modport master (
    output start, din_valid, din, append, dout_ready,
    input  in_ready, dout_valid, dout, crc_out, crc_ok
  );

  modport slave (
    input  start, din_valid, din, append, dout_ready,
    output in_ready, dout_valid, dout, crc_out, crc_ok
  );
endinterface

// File: rtl/usb_crc_engine.sv
// Parametrised USB CRC generator/checker (CRC5 and CRC16 from one RTL).
// Folds DW data bits per accepted beat into an MSB-feedback LFSR. On append it
// serialises the inverted CRC MSB-first as a handshaked sequence of WIDTH/DW
// beats. On receive, crc_ok flags that the register holds the residue.
// Ports:
//   i_clk   : clock, rising edge
//   i_rst_n : synchronous reset, active low
//   bus     : usb_crc_engine_if slave modport (data in, append out, status)
module usb_crc_engine #(
  parameter int               WIDTH   = 16,
  parameter logic [WIDTH-1:0] POLY    = 16'h8005,
  parameter logic [WIDTH-1:0] INIT    = {WIDTH{1'b1}},
  parameter logic [WIDTH-1:0] RESIDUE = 16'h800D,
  parameter int               DW      = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  usb_crc_engine_if.slave   bus
);

  localparam int BEATS = WIDTH / DW;
  localparam int CW    = $clog2(BEATS + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(BEATS - 1);

  typedef enum logic [0:0] {ST_ACC = 1'b0, ST_APP = 1'b1} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_crc;
  logic [WIDTH-1:0] r_snap;
  logic [CW-1:0]    r_cnt;
  logic             r_dout_valid;
  logic [DW-1:0]    r_dout;

  logic [WIDTH-1:0] w_crc_next;
  logic [WIDTH-1:0] w_init_next;
  logic [WIDTH-1:0] w_snap_shift;

  // Apply the serial bit step DW times, din[0] first.
  function automatic logic [WIDTH-1:0] fold(input logic [WIDTH-1:0] c,
                                            input logic [DW-1:0]    d);
    logic [WIDTH-1:0] r;
    logic             fb;
    r = c;
    for (int i = 0; i < DW; i++) begin
      fb = r[WIDTH-1] ^ d[i];
      r  = {r[WIDTH-2:0], 1'b0};
      if (fb) begin
        r = r ^ POLY;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  // Beat taken from the top of the snapshot: dout[k] = s[WIDTH-1-k], MSB on wire first.
  function automatic logic [DW-1:0] msb_beat(input logic [WIDTH-1:0] s);
    logic [DW-1:0] b;
    for (int k = 0; k < DW; k++) begin
      b[k] = s[WIDTH-1-k];
    end
    return b;
  endfunction

  // Next-register candidates: running fold, restart fold, and snapshot advance.
  always_comb begin
    w_crc_next   = bus.din_valid ? fold(r_crc, bus.din) : r_crc;
    w_init_next  = bus.din_valid ? fold(INIT, bus.din) : INIT;
    w_snap_shift = r_snap << DW;
  end

  // Control FSM, CRC register and append serialiser; start overrides the state.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state      <= ST_ACC;
      r_crc        <= INIT;
      r_snap       <= '0;
      r_cnt        <= '0;
      r_dout_valid <= 1'b0;
      r_dout       <= '0;
    end else if (bus.start) begin
      r_crc <= w_init_next;
      if (bus.append) begin
        r_state      <= ST_APP;
        r_snap       <= ~w_init_next;
        r_cnt        <= CNT_LOAD;
        r_dout_valid <= 1'b1;
        r_dout       <= msb_beat(~w_init_next);
      end else begin
        r_state      <= ST_ACC;
        r_snap       <= '0;
        r_cnt        <= '0;
        r_dout_valid <= 1'b0;
        r_dout       <= '0;
      end
    end else begin
      case (r_state)
        ST_ACC: begin
          r_crc <= w_crc_next;
          if (bus.append) begin
            // Snapshot includes a beat folded in this same cycle.
            r_state      <= ST_APP;
            r_snap       <= ~w_crc_next;
            r_cnt        <= CNT_LOAD;
            r_dout_valid <= 1'b1;
            r_dout       <= msb_beat(~w_crc_next);
          end else begin
            r_dout_valid <= 1'b0;
            r_dout       <= '0;
          end
        end
        ST_APP: begin
          // Data and append requests are ignored here; only the handshake advances.
          if (r_dout_valid && bus.dout_ready) begin
            if (r_cnt == '0) begin
              r_state      <= ST_ACC;
              r_snap       <= '0;
              r_dout_valid <= 1'b0;
              r_dout       <= '0;
            end else begin
              r_snap <= w_snap_shift;
              r_cnt  <= r_cnt - CW'(1);
              r_dout <= msb_beat(w_snap_shift);
            end
          end else begin
            r_snap <= r_snap;
          end
        end
        default: begin
          r_state      <= ST_ACC;
          r_snap       <= '0;
          r_cnt        <= '0;
          r_dout_valid <= 1'b0;
          r_dout       <= '0;
        end
      endcase
    end
  end

  assign bus.in_ready   = (r_state == ST_ACC);
  assign bus.dout_valid = r_dout_valid;
  assign bus.dout       = r_dout;
  assign bus.crc_out    = r_crc;
  assign bus.crc_ok     = (r_crc == RESIDUE);

endmodule

// File: doc/usb_crc_engine.md
# usb_crc_engine

Parametrised CRC generator/checker for the USB serial datapath. It generalises the fixed 1-bit CRC16 LFSR in three ways: configurable polynomial, width, init and residue (CRC5 and CRC16 from one RTL); configurable bits per cycle; and added behaviour for transmit and receive. On transmit it serialises the inverted CRC as a handshaked append phase. On receive it flags the residue match. It sits between the bit-stuffer/destuffer and the packet engines.

## Interface
- WIDTH, 16: CRC width, 2..32.
- POLY, 16'h8005: generator polynomial without the x^WIDTH term; bit i is the x^i coefficient.
- INIT, all ones: register value after reset or `start`.
- RESIDUE, 16'h800D: good-packet residue (CRC5 uses 5'h0C).
- DW, 1: data bits per beat, 1..8; WIDTH % DW == 0 is required.

- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous reset, active low.
- start  in  1  reinitialise the register to INIT; aborts any append.
- din_valid  in  1  din is presented this cycle.
- din  in  DW  data bits; din[0] is first on the wire.
- in_ready  out  1  high in ACC state.
- append  in  1  request transmission of the current CRC.
- dout_valid  out  1  append beat is valid.
- dout  out  DW  append bits; dout[0] is first on the wire.
- dout_ready  in  1  consumer accepts the beat.
- crc_out  out  WIDTH  live CRC register.
- crc_ok  out  1  (crc_out == RESIDUE), combinational from the register.

## Operation
- Bit step, matching the existing CRC16: fb = crc[WIDTH-1] ^ d; crc = (crc << 1) truncated to WIDTH; if fb then crc ^= POLY.
- Fold: an accepted beat (din_valid & in_ready) applies the bit step DW times, din[0] first. crc_out updates on the next edge.
- States:
  - ACC: accumulate; in_ready=1; dout_valid=0.
  - APP: shift out; in_ready=0.
- ACC -> APP when append is high.
  - On entry, the shift register snap is loaded with ~crc_next. crc_next is crc folded with din if din_valid is high in the same cycle, otherwise the current crc.
  - The beat counter is loaded with WIDTH/DW - 1.
  - crc_out keeps crc_next; it is not altered by the append.
- In APP:
  - dout[k] = snap[WIDTH-1-k] for k = 0..DW-1, so the CRC MSB is on the wire first.
  - On each dout_valid & dout_ready: snap <<= DW, counter decrements.
  - The beat with counter == 0 returns the block to ACC.
  - dout and dout_valid hold stable while dout_ready is low.
- din_valid in APP is ignored and does not change the register. append in APP is ignored.
- start has priority over everything:
  - crc <= INIT, or INIT folded with din if din_valid is high in the same cycle.
  - The state goes to ACC, dout_valid goes low next cycle, and the counter is cleared.
  - start together with append: the append takes the CRC of INIT (folded with din if present).
- The receive check needs no mode. Feeding the data followed by the received CRC bits leaves crc_ok = 1 for an error-free packet.

## Timing
- Reset (rst_n low at a clk edge):
  - crc_out = INIT, state ACC, in_ready = 1.
  - dout_valid = 0, dout = 0, counter = 0.
  - crc_ok = (INIT == RESIDUE), which is 0 for the defaults.
- Fold latency: 1 cycle from the accepted beat to crc_out and crc_ok.
- Append latency: dout_valid rises the cycle after append is sampled. The minimum append lasts WIDTH/DW cycles with dout_ready held high. in_ready returns high the cycle after the last beat handshake.
- Back-to-back: din_valid may be asserted every cycle in ACC, with full throughput.
- Reset mid-append drops dout_valid on the next edge. No partial beat is retained.
- dout is 0 whenever dout_valid is 0.

## Test plan
- CRC5 (WIDTH=5, POLY=5'h05, INIT=5'h1F, RESIDUE=5'h0C, DW=1), SETUP token address 0, endpoint 0:
  - Stimulus: 11 zero bits, then append with dout_ready=1.
  - Required: crc_out = 5'h17; dout sequence 0,1,0,0,0.
  - Then start, feed the 11 zeros plus 0,1,0,0,0: crc_ok = 1, crc_out = 5'h0C.
- CRC16 defaults with DW=1 vs DW=8, bytes 00 01 02 03:
  - Required: both produce identical crc_out.
  - Appending with DW=8 gives 2 beats whose bits equal the 16 DW=1 beats in order.
  - Feeding the data plus the appended bytes back gives crc_ok = 1 and crc_out = 16'h800D.
- Backpressure: toggle dout_ready 1/0 pseudo-randomly during a CRC16 append.
  - Required: dout is stable while not ready; exactly 16 (DW=1) handshakes; din_valid pulses in APP leave crc_out unchanged.
- append in the same cycle as the last din beat:
  - Required: the appended CRC includes that beat; compare against the two-cycle sequence.
- start asserted on the third beat of an append:
  - Required: dout_valid = 0 next cycle, crc_out = INIT, in_ready = 1.
  - rst_n low mid-append gives the same result.
- Single-bit error: flip one data bit before the check.
  - Required: crc_ok = 0.
